// File: rtl/load_use_hazard.sv
// load_use_hazard: ID-stage stall/flush controller for a 5-stage MIPS pipeline.
// Detects load-use hazards (except load->store-data, resolved by forwarding at
// MEM), freezes the pipeline while data memory is busy, and flushes IF/ID on
// a taken branch.
// Optional feature macro: STALL_COUNTER_EN (saturating count of pcWrite=0
// cycles). When undefined, stallCount is tied to zero.
//
// state  | meaning
// -------+------------------------------------------------------------
// RUN    | normal flow; hazards are checked
// BUBBLE | one cycle after a load-use stall; hazard masked
// FREEZE | data memory busy; everything held until memBusy drops
module load_use_hazard #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             idIsStore,
  input  logic             exMemRead,
  input  logic [4:0]       exRt,
  input  logic             memBusy,
  input  logic             branchTaken,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             pipeWrite,
  output logic             idExBubble,
  output logic             ifIdFlush,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_hazard;
  logic   w_pc_write;
  logic   w_if_id_write;
  logic   w_pipe_write;
  logic   w_bubble;
  logic   w_flush;

  // Store data (rt of a sw) is forwarded at MEM, so only rs counts for stores.
  assign w_hazard = exMemRead && (exRt != 5'd0) &&
                    ((idUsesRs && (idRs == exRt)) ||
                     (idUsesRt && (idRt == exRt) && !idIsStore));

  // Next-state and output decode; priority memBusy > branchTaken > hazard.
  // FREEZE with memBusy low behaves exactly like RUN, so they share a branch.
  always_comb begin
    w_next        = RUN;
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_pipe_write  = 1'b1;
    w_bubble      = 1'b0;
    w_flush       = 1'b0;
    if (memBusy) begin
      w_next        = FREEZE;
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_pipe_write  = 1'b0;
    end else if (branchTaken) begin
      // ID holds a wrong-path instruction, so any hazard it shows is moot.
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else begin
      case (r_state)
        RUN, FREEZE: begin
          if (w_hazard) begin
            w_next        = BUBBLE;
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
          end
        end
        BUBBLE:  w_next = RUN;
        default: w_next = RUN;
      endcase
    end
    // Hold the pipeline quiet while reset is asserted.
    if (rst) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_pipe_write  = 1'b0;
      w_bubble      = 1'b0;
      w_flush       = 1'b0;
    end
  end

  assign pcWrite    = w_pc_write;
  assign ifIdWrite  = w_if_id_write;
  assign pipeWrite  = w_pipe_write;
  assign idExBubble = w_bubble;
  assign ifIdFlush  = w_flush;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Count cycles where the PC is held; saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stallCount = r_stall_cnt;
`else
  assign stallCount = '0;
`endif

endmodule

// File: tb/tb_load_use_hazard.sv
// Directed bench for load_use_hazard. Control outputs are compared as a packed
// vector {pcWrite, ifIdWrite, pipeWrite, idExBubble, ifIdFlush}.
module tb_load_use_hazard;
  localparam int CNT_W = 4;  // small width so saturation is reachable
`ifdef STALL_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam logic [4:0] ALLEN = 5'b11100;
  localparam logic [4:0] FRZ   = 5'b00000;
  localparam logic [4:0] STALL = 5'b00110;
  localparam logic [4:0] FLUSH = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] idRs, idRt, exRt;
  logic idUsesRs, idUsesRt, idIsStore, exMemRead, memBusy, branchTaken;
  logic pcWrite, ifIdWrite, pipeWrite, idExBubble, ifIdFlush;
  logic [CNT_W-1:0] stallCount;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  load_use_hazard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .idIsStore(idIsStore), .exMemRead(exMemRead), .exRt(exRt),
    .memBusy(memBusy), .branchTaken(branchTaken),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .pipeWrite(pipeWrite),
    .idExBubble(idExBubble), .ifIdFlush(ifIdFlush), .stallCount(stallCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic st, input logic mr,
                       input logic [4:0] ert, input logic mb, input logic br);
    idRs = rs; idRt = rt; idUsesRs = urs; idUsesRt = urt; idIsStore = st;
    exMemRead = mr; exRt = ert; memBusy = mb; branchTaken = br;
  endtask

  // Settle, compare control vector, then advance one clock (edge + 1).
  task automatic step(input string tag, input logic [4:0] exp_ctl);
    #1;
    check(tag, {27'd0, pcWrite, ifIdWrite, pipeWrite, idExBubble, ifIdFlush},
          {27'd0, exp_ctl});
    if (exp_ctl[4] == 1'b0 && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    check(tag, {{(32-CNT_W){1'b0}}, stallCount}, CNT_ON ? exp_cnt : 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset_ctl", {27'd0, pcWrite, ifIdWrite, pipeWrite, idExBubble, ifIdFlush}, 0);
    check_cnt("reset_cnt");
    @(posedge clk); #1;
    rst = 1'b0;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);        step("idle", ALLEN);

    // lw r5; add uses rs=r5
    drive(5, 0, 1, 0, 0, 1, 5, 0, 0);        step("lu_rs_stall", STALL);
                                             step("lu_bubble_mask", ALLEN);
                                             step("lu_rs_again", STALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);        step("lu_after", ALLEN);
    check_cnt("cnt_lu");

    // stores: rt-only dependency never stalls, rs dependency does
    drive(3, 5, 1, 1, 1, 1, 5, 0, 0);        step("sw_rt_only", ALLEN);
    drive(5, 5, 1, 1, 1, 1, 5, 0, 0);        step("sw_rs_stall", STALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);        step("sw_after", ALLEN);

    // non-store rt dependency, and rt match without use
    drive(3, 5, 1, 1, 0, 1, 5, 0, 0);        step("lu_rt_stall", STALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);        step("rt_after", ALLEN);
    drive(3, 5, 1, 0, 0, 1, 5, 0, 0);        step("rt_unused", ALLEN);

    // r0 and non-load never stall
    drive(0, 0, 1, 1, 0, 1, 0, 0, 0);        step("exrt_zero", ALLEN);
    drive(7, 7, 1, 1, 0, 0, 7, 0, 0);        step("not_load", ALLEN);
    check_cnt("cnt_mid");

    // memBusy for 3 cycles over a hazard, then single bubble
    drive(5, 0, 1, 0, 0, 1, 5, 1, 0);        step("frz1", FRZ);
                                             step("frz2", FRZ);
                                             step("frz3", FRZ);
    memBusy = 1'b0;                          step("frz_exit_stall", STALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);        step("frz_after", ALLEN);
    check_cnt("cnt_frz");

    // branch overrides hazard, stays in RUN
    drive(5, 0, 1, 0, 0, 1, 5, 0, 1);        step("br_flush", FLUSH);
    branchTaken = 1'b0;                      step("br_run_stall", STALL);
    // memBusy while in BUBBLE freezes at once, no duplicate bubble
    memBusy = 1'b1;                          step("bub_frz", FRZ);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);        step("bub_frz_exit", ALLEN);
    // branch while in BUBBLE flushes, then back to RUN
    drive(5, 0, 1, 0, 0, 1, 5, 0, 0);        step("bub_br_pre", STALL);
    branchTaken = 1'b1;                      step("bub_br_flush", FLUSH);
    branchTaken = 1'b0;                      step("bub_br_run", STALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);        step("bub_br_after", ALLEN);
    check_cnt("cnt_br");

    // long freeze saturates the counter
    memBusy = 1'b1;
    for (int i = 0; i < 6; i++) step("long_frz", FRZ);
    check_cnt("cnt_sat");

    // async reset while in FREEZE
    #1;
    check("pre_rst_frz", {27'd0, pcWrite, ifIdWrite, pipeWrite, idExBubble, ifIdFlush}, 0);
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    check("rst_async_ctl", {27'd0, pcWrite, ifIdWrite, pipeWrite, idExBubble, ifIdFlush}, 0);
    check_cnt("rst_async_cnt");
    @(posedge clk); #1;
    rst = 1'b0;
    memBusy = 1'b0;                          step("post_rst", ALLEN);
    check_cnt("cnt_post_rst");
    drive(5, 0, 1, 0, 0, 1, 5, 0, 0);        step("post_rst_stall", STALL);
                                             step("post_rst_bubble", ALLEN);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/load_use_hazard.md
# load_use_hazard

Stall and flush controller for the 5-stage MIPS pipeline, sitting at the ID stage. It catches loads whose destination register is needed by the instruction behind them before MEM/WB forwarding can supply it. Load→store-data dependencies are already resolved at MEM by store-data forwarding, so this block does not stall for them. It also freezes the whole pipeline while data memory is busy and flushes IF/ID on a taken branch. It drives the PC, IF/ID and downstream pipeline-register enables, plus an optional stall counter.

## Interface
- Parameters:
- CNT_W, 16, width of stall performance counter
- Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- idRs  input  5  rs field of instruction in ID
- idRt  input  5  rt field of instruction in ID
- idUsesRs  input  1  ID instruction reads rs
- idUsesRt  input  1  ID instruction reads rt
- idIsStore  input  1  ID instruction is sw (rt is store data)
- exMemRead  input  1  instruction in EX is a load
- exRt  input  5  destination register of load in EX
- memBusy  input  1  data memory not ready this cycle
- branchTaken  input  1  branch in EX resolved taken
- pcWrite  output  1  PC register enable
- ifIdWrite  output  1  IF/ID register enable
- pipeWrite  output  1  ID/EX, EX/MEM, MEM/WB enables
- idExBubble  output  1  load NOP into ID/EX (zero control bits)
- ifIdFlush  output  1  clear IF/ID to NOP
- stallCount  output  CNT_W  cycles with pcWrite=0 (see Configuration)

## Operation
- hazard = exMemRead & (exRt≠0) & ((idUsesRs & idRs==exRt) | (idUsesRt & idRt==exRt & ~idIsStore)).
- FSM states: RUN, BUBBLE, FREEZE. Reset state RUN.
- Priority in every state: memBusy > branchTaken > hazard.
- RUN:
  - memBusy=1 → pcWrite=ifIdWrite=pipeWrite=0, no bubble, no flush; next FREEZE.
  - else if branchTaken → ifIdFlush=1, idExBubble=1, pcWrite=ifIdWrite=pipeWrite=1; next RUN. Any hazard is ignored because the ID instruction is wrong-path.
  - else if hazard → pcWrite=ifIdWrite=0, pipeWrite=1, idExBubble=1; next BUBBLE.
  - else → all enables 1, bubble/flush 0; next RUN.
- BUBBLE (exactly one cycle after a load-use stall): hazard is masked; enables 1 unless memBusy (→FREEZE) or branchTaken (flush as in RUN). Next RUN.
- FREEZE: all enables 0, bubble/flush 0 while memBusy=1. When memBusy=0, outputs are evaluated exactly as in RUN in the same cycle, and the next state follows RUN rules.
- Outputs are combinational from state and inputs. Only state and stallCount are registered.

## Timing
- Load-use stall: detected and applied in the same cycle the load is in EX. Exactly one bubble is inserted. The dependent instruction leaves ID on the following cycle and picks up the load data through MEM/WB forwarding.
- Back-to-back dependent loads (lw r1; lw r2,0(r1)): one bubble. The second load may then stall its own consumer normally.
- memBusy arriving mid-stall (in BUBBLE) freezes immediately. The pending bubble is not duplicated.
- exRt=0 never stalls. A store whose only dependency is on rt never stalls. A store dependency on rs (base address) stalls.
- Reset (asynchronous, any state): state→RUN and stallCount→0 immediately. While rst=1, pcWrite=ifIdWrite=pipeWrite=0 and idExBubble=ifIdFlush=0.
- stallCount saturates at 2^CNT_W−1 and does not wrap.

## Configuration
- STALL_COUNTER_EN defined: stallCount increments by 1 on each rising edge where pcWrite=0 and rst=0. This covers both load-use and freeze cycles.
- Not defined: counter logic is removed and stallCount is tied to 0.

## Test plan
- lw r5 in EX (exRt=5, exMemRead=1), ID add reads idRs=5 → pcWrite=0, ifIdWrite=0, idExBubble=1 for one cycle. Next cycle, with the same inputs held, all enables are 1 (BUBBLE masks the hazard).
- exRt=5, ID sw with idRt=5, idIsStore=1, idUsesRs=1, idRs=3 → no stall, all enables 1. The same case with idRs=5 → one-cycle stall.
- exRt=0 with idRs=0 → no stall. exMemRead=0 with matching registers → no stall.
- memBusy high for 3 cycles during a RUN hazard → 3 cycles of all enables 0 with no bubble. On the first cycle memBusy=0, a single bubble is issued. With STALL_COUNTER_EN, stallCount=4 afterwards.
- branchTaken=1 together with a hazard → ifIdFlush=1, idExBubble=1, pcWrite=1, and state stays RUN.
- rst asserted asynchronously while in FREEZE → state returns to RUN and stallCount=0 before the next edge. After release with memBusy=0 and no hazard, all enables are 1.
